// File: rtl/strobe_sched.sv
// strobe_sched: NCHAN divide-by-(rate+1) strobe counters sharing one base tick.
// Each strobe becomes a pending request. A round-robin arbiter offers one
// shared serial datapath to pending channels through an ack/done handshake.
// A strobe that arrives while the previous request is still unserviced
// raises a sticky overrun flag for that channel.
module strobe_sched #(
    parameter int NCHAN = 4,
    parameter int IDXW  = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             strobe_in,
    input  logic [NCHAN-1:0] chan_en,
    input  logic             cfg_write,
    input  logic [IDXW-1:0]  cfg_addr,
    input  logic [7:0]       cfg_rate,
    input  logic             dp_ack,
    input  logic             dp_done,
    output logic [NCHAN-1:0] strobe_out,
    output logic [NCHAN-1:0] pending,
    output logic [NCHAN-1:0] overrun,
    output logic             grant_valid,
    output logic [IDXW-1:0]  grant_idx,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, OFFER, RUN} state_t;

    state_t           state;
    logic [7:0]       rate_reg [NCHAN];
    logic [7:0]       cnt      [NCHAN];
    logic [IDXW-1:0]  rr_ptr;
    logic [NCHAN-1:0] clr;
    logic             offer_live;
    logic             ack_take;
    logic             pick_found;
    logic [IDXW-1:0]  pick_idx;

    // The offer stays alive only while its channel still has a live request;
    // a chan_en drop withdraws it and blocks an ack in the same cycle.
    assign offer_live = (state == OFFER) && pending[grant_idx] && chan_en[grant_idx];
    assign ack_take   = offer_live && dp_ack;
    assign busy       = (state != IDLE);

    for (genvar i = 0; i < NCHAN; i++) begin : g_chan
        logic cfg_hit;
        assign cfg_hit       = cfg_write && (cfg_addr == IDXW'(i));
        assign strobe_out[i] = (cnt[i] == 8'd0) && chan_en[i] && enable && strobe_in;
        assign clr[i]        = ack_take && (grant_idx == IDXW'(i));

        // Rate register survives enable low; only reset clears it.
        always_ff @(posedge clock) begin
            if (reset)
                rate_reg[i] <= 8'd0;
            else if (cfg_hit)
                rate_reg[i] <= cfg_rate;
        end

        // Divider: reload on the zero tick so a new rate applies from the next period.
        always_ff @(posedge clock) begin
            if (reset || !enable || !chan_en[i])
                cnt[i] <= 8'd0;
            else if (strobe_in)
                cnt[i] <= (cnt[i] == 8'd0) ? rate_reg[i] : cnt[i] - 8'd1;
        end

        // Request flag: a fresh strobe beats a simultaneous ack clear.
        always_ff @(posedge clock) begin
            if (reset || !enable || !chan_en[i])
                pending[i] <= 1'b0;
            else if (strobe_out[i])
                pending[i] <= 1'b1;
            else if (clr[i])
                pending[i] <= 1'b0;
        end

        // Sticky overrun: strobe landed on a request that is not being taken now.
        always_ff @(posedge clock) begin
            if (reset || !enable)
                overrun[i] <= 1'b0;
            else if (cfg_hit)
                overrun[i] <= 1'b0;
            else if (strobe_out[i] && pending[i] && !clr[i])
                overrun[i] <= 1'b1;
        end
    end

    // Round-robin pick: first pending channel after rr_ptr, wrapping mod NCHAN.
    always_comb begin
        int j;
        j          = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 1; k <= NCHAN; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NCHAN)
                j = j - NCHAN;
            if (!pick_found && pending[j]) begin
                pick_found = 1'b1;
                pick_idx   = IDXW'(j);
            end
        end
    end

    // Grant FSM: IDLE picks, OFFER waits for ack or withdrawal, RUN waits for done.
    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            rr_ptr      <= IDXW'(NCHAN - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state       <= OFFER;
                        grant_valid <= 1'b1;
                        grant_idx   <= pick_idx;
                    end
                end
                OFFER: begin
                    if (!offer_live) begin
                        state       <= IDLE;
                        grant_valid <= 1'b0;
                    end else if (dp_ack) begin
                        state       <= RUN;
                        grant_valid <= 1'b0;
                        rr_ptr      <= grant_idx;
                    end
                end
                RUN: begin
                    if (dp_done)
                        state <= IDLE;
                end
                default: begin
                    state       <= IDLE;
                    grant_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_strobe_sched.sv
// Bench for strobe_sched: vector table for the round-robin handshake, hand
// sequences for divider periods, rate change, overrun, withdrawal and enable
// drop, then randomized traffic against a behavioural model.
module tb_strobe_sched;

    localparam int NCHAN = 4;
    localparam int IDXW  = 2;

    logic             clock = 1'b0;
    logic             reset, enable, strobe_in;
    logic [NCHAN-1:0] chan_en;
    logic             cfg_write;
    logic [IDXW-1:0]  cfg_addr;
    logic [7:0]       cfg_rate;
    logic             dp_ack, dp_done;
    logic [NCHAN-1:0] strobe_out, pending, overrun;
    logic             grant_valid;
    logic [IDXW-1:0]  grant_idx;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;

    strobe_sched #(.NCHAN(NCHAN), .IDXW(IDXW)) dut (
        .clock(clock), .reset(reset), .enable(enable), .strobe_in(strobe_in),
        .chan_en(chan_en), .cfg_write(cfg_write), .cfg_addr(cfg_addr),
        .cfg_rate(cfg_rate), .dp_ack(dp_ack), .dp_done(dp_done),
        .strobe_out(strobe_out), .pending(pending), .overrun(overrun),
        .grant_valid(grant_valid), .grant_idx(grant_idx), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       si, ack, done;
        logic [3:0] so, pend;
        logic       gv;
        logic [1:0] gi;
        logic       bz;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b1; strobe_in = 1'b0; chan_en = '0;
        cfg_write = 1'b0; cfg_addr = '0; cfg_rate = 8'd0; dp_ack = 1'b0; dp_done = 1'b0;
        cyc();
        reset = 1'b0;
    endtask

    task automatic write_rate(input int ch, input int r);
        cfg_write = 1'b1; cfg_addr = IDXW'(ch); cfg_rate = 8'(r);
        cyc();
        cfg_write = 1'b0;
    endtask

    // ---------------- behavioural model ----------------
    int         m_cnt [NCHAN];
    int         m_rate[NCHAN];
    bit [3:0]   m_pend, m_ovr;
    int         m_offer;      // channel being offered, -1 when none
    bit         m_run;
    int         m_last;       // last channel that took service
    int         m_gi;

    task automatic model_init(input bit clr_rates);
        for (int i = 0; i < NCHAN; i++) begin
            m_cnt[i] = 0;
            if (clr_rates) m_rate[i] = 0;
        end
        m_pend = '0; m_ovr = '0; m_offer = -1; m_run = 1'b0; m_last = NCHAN - 1; m_gi = 0;
    endtask

    function automatic bit [3:0] model_so();
        bit [3:0] s;
        for (int i = 0; i < NCHAN; i++)
            s[i] = enable && strobe_in && chan_en[i] && (m_cnt[i] == 0);
        return s;
    endfunction

    task automatic model_step();
        bit [3:0] so;
        int       n_cnt[NCHAN];
        bit [3:0] n_pend, n_ovr;
        int       n_offer, n_last, n_gi;
        bit       n_run, take, clr, found;
        int       idx;
        if (reset) begin
            model_init(1'b1);
            return;
        end
        so = model_so();
        n_pend = m_pend; n_ovr = m_ovr; n_offer = m_offer; n_run = m_run;
        n_last = m_last; n_gi = m_gi;
        for (int i = 0; i < NCHAN; i++) n_cnt[i] = m_cnt[i];
        if (!enable) begin
            for (int i = 0; i < NCHAN; i++) n_cnt[i] = 0;
            n_pend = '0; n_ovr = '0; n_offer = -1; n_run = 1'b0; n_last = NCHAN - 1; n_gi = 0;
        end else begin
            take = (m_offer >= 0) && m_pend[m_offer] && chan_en[m_offer] && dp_ack;
            for (int i = 0; i < NCHAN; i++) begin
                clr = take && (m_offer == i);
                if (!chan_en[i])   n_pend[i] = 1'b0;
                else if (so[i])    n_pend[i] = 1'b1;
                else if (clr)      n_pend[i] = 1'b0;
                if (so[i] && m_pend[i] && !clr) n_ovr[i] = 1'b1;
                if (!chan_en[i])   n_cnt[i] = 0;
                else if (strobe_in) n_cnt[i] = (m_cnt[i] == 0) ? m_rate[i] : m_cnt[i] - 1;
            end
            if (m_offer >= 0) begin
                if (!(m_pend[m_offer] && chan_en[m_offer])) n_offer = -1;
                else if (dp_ack) begin
                    n_last = m_offer; n_run = 1'b1; n_offer = -1;
                end
            end else if (m_run) begin
                if (dp_done) n_run = 1'b0;
            end else if (m_pend != 0) begin
                found = 1'b0;
                for (int k = 1; k <= NCHAN; k++) begin
                    idx = (m_last + k) % NCHAN;
                    if (!found && m_pend[idx]) begin
                        found = 1'b1; n_offer = idx; n_gi = idx;
                    end
                end
            end
        end
        if (cfg_write && int'(cfg_addr) < NCHAN) begin
            m_rate[cfg_addr] = int'(cfg_rate);
            n_ovr[cfg_addr] = 1'b0;
        end
        for (int i = 0; i < NCHAN; i++) m_cnt[i] = n_cnt[i];
        m_pend = n_pend; m_ovr = n_ovr; m_offer = n_offer; m_run = n_run;
        m_last = n_last; m_gi = n_gi;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vec_t       tbl[18];
        logic [19:0] got20, exp20;
        int         e0, e1, e2, n2, rfail_prints;
        logic [15:0] act16, exp16;

        // Reset state
        do_reset();
        smp();
        chk("rst_strobe", 32'(strobe_out), 32'h0);
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        chk("rst_gv", 32'(grant_valid), 32'h0);
        chk("rst_gi", 32'(grant_idx), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        // Round-robin over ch0,2,3 with done 3 cycles after ack; rates are 0.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 4'b1101, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 4'b1101, 1'b0, 2'd0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b1101, 1'b1, 2'd0, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b1100, 1'b0, 2'd0, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b1100, 1'b0, 2'd0, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 4'b1100, 1'b0, 2'd0, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b1100, 1'b0, 2'd0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b1100, 1'b1, 2'd2, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b1000, 1'b0, 2'd2, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b1000, 1'b0, 2'd2, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 4'b0000, 4'b1000, 1'b0, 2'd2, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b1000, 1'b0, 2'd2, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 4'b0000, 4'b1000, 1'b1, 2'd3, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 4'b1101, 4'b0000, 1'b0, 2'd3, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b1101, 1'b0, 2'd3, 1'b1};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 4'b0000, 4'b1101, 1'b0, 2'd3, 1'b1};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b1101, 1'b0, 2'd3, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b1101, 1'b1, 2'd0, 1'b1};
        do_reset();
        chan_en = 4'b1101;
        for (int r = 0; r < 18; r++) begin
            strobe_in = tbl[r].si; dp_ack = tbl[r].ack; dp_done = tbl[r].done;
            smp();
            chk($sformatf("vec%0d {so,pend,gv,gi,busy}", r),
                32'({strobe_out, pending, grant_valid, grant_idx, busy}),
                32'({tbl[r].so, tbl[r].pend, tbl[r].gv, tbl[r].gi, tbl[r].bz}));
            cyc();
        end

        // Divider periods: rate 3 / 0 / 255 on ch0 / ch1 / ch2
        do_reset();
        write_rate(0, 3); write_rate(1, 0); write_rate(2, 255);
        chan_en = 4'b1111; strobe_in = 1'b1;
        e0 = 0; e1 = 0; e2 = 0; n2 = 0;
        for (int c = 0; c < 520; c++) begin
            smp();
            if (strobe_out[0] != (c % 4 == 0))   e0++;
            if (strobe_out[1] != 1'b1)           e1++;
            if (strobe_out[2] != (c % 256 == 0)) e2++;
            if (strobe_out[2]) n2++;
            cyc();
        end
        chk("div4_errs", 32'(e0), 32'd0);
        chk("div1_errs", 32'(e1), 32'd0);
        chk("div256_errs", 32'(e2), 32'd0);
        chk("div256_count", 32'(n2), 32'd3);

        // Rate change 1 -> 5 mid-period; write also clears overrun[0]
        do_reset();
        write_rate(0, 1);
        chan_en = 4'b0001; strobe_in = 1'b1;
        got20 = '0;
        exp20 = 20'b0100_0001_0000_0101_0101;   // strobes at 0,2,4,6,12,18
        for (int c = 0; c < 20; c++) begin
            if (c == 5) begin cfg_write = 1'b1; cfg_addr = 2'd0; cfg_rate = 8'd5; end
            else cfg_write = 1'b0;
            smp();
            got20[c] = strobe_out[0];
            if (c == 4) chk("ovr0_before_write", 32'(overrun[0]), 32'd1);
            if (c == 6) chk("ovr0_after_write", 32'(overrun[0]), 32'd0);
            cyc();
        end
        cfg_write = 1'b0;
        chk("rate_change_pattern", 32'(got20), 32'(exp20));

        // Overrun on ch1 (rate 0) with ack held low; then strobe on the ack cycle
        do_reset();
        chan_en = 4'b0010; strobe_in = 1'b1;
        cyc(); cyc();
        strobe_in = 1'b0; cfg_write = 1'b1; cfg_addr = 2'd1; cfg_rate = 8'd0;
        smp();
        chk("ovr1_second_strobe", 32'(overrun[1]), 32'd1);
        chk("pend1_held", 32'(pending[1]), 32'd1);
        chk("offer1", 32'({grant_valid, grant_idx}), 32'({1'b1, 2'd1}));
        cyc();
        cfg_write = 1'b0; strobe_in = 1'b1; dp_ack = 1'b1;
        smp();
        chk("ovr1_cleared", 32'(overrun[1]), 32'd0);
        cyc();
        strobe_in = 1'b0; dp_ack = 1'b0;
        smp();
        chk("ack_strobe_pend", 32'(pending[1]), 32'd1);
        chk("ack_strobe_no_ovr", 32'(overrun[1]), 32'd0);
        chk("ack_strobe_run", 32'({grant_valid, busy}), 32'({1'b0, 1'b1}));

        // Withdrawal: offer ch2, drop chan_en[2]; ch0 and ch3 pending, rr_ptr still 3
        do_reset();
        chan_en = 4'b1100; strobe_in = 1'b1;
        cyc();
        strobe_in = 1'b0;
        cyc();
        chan_en = 4'b1001; strobe_in = 1'b1;
        smp();
        chk("offer2", 32'({grant_valid, grant_idx}), 32'({1'b1, 2'd2}));
        cyc();
        strobe_in = 1'b0;
        smp();
        chk("withdraw_gv_busy", 32'({grant_valid, busy}), 32'h0);
        chk("withdraw_pending", 32'(pending), 32'b1001);
        cyc();
        smp();
        chk("after_withdraw_grant", 32'({grant_valid, grant_idx}), 32'({1'b1, 2'd0}));

        // Enable dropped for one cycle in RUN
        do_reset();
        chan_en = 4'b0100; strobe_in = 1'b1;
        cyc(); cyc();
        dp_ack = 1'b1;
        smp();
        chk("en_offer2_ovr", 32'({grant_valid, grant_idx, overrun[2]}), 32'({1'b1, 2'd2, 1'b1}));
        cyc();
        dp_ack = 1'b0; strobe_in = 1'b0; enable = 1'b0;
        smp();
        chk("en_low_run", 32'({busy, pending[2], strobe_out}), 32'({1'b1, 1'b1, 4'b0000}));
        cyc();
        enable = 1'b1; dp_done = 1'b1;
        smp();
        chk("en_cleared", 32'({pending, overrun, grant_valid, grant_idx, busy}), 32'h0);
        cyc();
        dp_done = 1'b0;
        smp();
        chk("done_ignored", 32'({grant_valid, busy}), 32'h0);

        // Randomized traffic against the behavioural model
        do_reset();
        model_init(1'b1);
        chan_en = 4'b1111;
        rfail_prints = 0;
        for (int c = 0; c < 4000; c++) begin
            reset     = ($urandom_range(499) == 0);
            enable    = ($urandom_range(199) != 0);
            strobe_in = $urandom_range(1) == 1;
            if ($urandom_range(49) == 0) chan_en[$urandom_range(NCHAN-1)] ^= 1'b1;
            cfg_write = ($urandom_range(19) == 0);
            cfg_addr  = IDXW'($urandom_range(NCHAN-1));
            cfg_rate  = ($urandom_range(15) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(5));
            dp_ack    = ($urandom_range(2) == 0);
            dp_done   = ($urandom_range(3) == 0);
            smp();
            act16 = {strobe_out, pending, overrun, grant_valid, grant_idx, busy};
            exp16 = {model_so(), m_pend, m_ovr, (m_offer >= 0), IDXW'(m_gi), (m_offer >= 0) || m_run};
            n_tests++;
            if (act16 !== exp16) begin
                n_fail++;
                if (rfail_prints < 10) begin
                    rfail_prints++;
                    $display("FAIL rand cyc%0d {so,pend,ovr,gv,gi,busy}: got %b want %b", c, act16, exp16);
                end
            end
            model_step();
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
